// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store unit definitions: FSM states, funct3 encodings and
// request legality check.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths only exist for loads.
    function automatic logic lsu_bad(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        case (f3)
            F3_B:         return 1'b0;
            F3_H:         return off[0];
            F3_W:         return off != 2'b00;
            F3_BU, F3_HU: return we;
            default:      return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/enables toward memory, load data
// shift and sign/zero extension back toward the core.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_data = st_wdata << {st_off, 3'b000};
        case (st_funct3)
            F3_B, F3_BU: st_be = 4'b0001 << st_off;
            F3_H, F3_HU: st_be = 4'b0011 << st_off;
            default:     st_be = 4'b1111;
        endcase
    end

    always_comb begin
        shifted = ld_word >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'h0, shifted[7:0]};
            F3_HU:   ld_data = {16'h0, shifted[15:0]};
            F3_W:    ld_data = shifted;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller between the core and a
// req/gnt/rvalid memory port.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    lsu_state_e state;

    logic          we_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          hs;
    logic          bad;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n;
    logic [31:0]   rdata_ext;

    assign hs    = req_valid & req_ready;
    assign bad   = lsu_bad(req_we, req_funct3, req_addr[1:0]);
    assign cnt_n = cnt + CW'(1);

    lsu_align u_align (
        .st_off    (req_addr[1:0]),
        .st_funct3 (req_funct3),
        .st_wdata  (req_wdata),
        .st_be     (be_n),
        .st_data   (wdata_n),
        .ld_off    (off_q),
        .ld_funct3 (f3_q),
        .ld_word   (mem_rdata),
        .ld_data   (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= 3'h0;
            off_q     <= 2'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_we    <= req_we;
                            mem_be    <= be_n;
                            mem_wdata <= wdata_n;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (we_q) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= rdata_ext;
                    end else if (cnt_n == TO_MAX) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end else begin
                        cnt <= cnt_n;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    cnt       <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: alignment, extension, grant stalls,
// request errors, WAIT timeout and mid-transaction reset.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int vectors;
    int miscompares;

    lsu_ctrl #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we, mem_be} !== 9'b1_0000_0000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 100000000",
                     {req_ready, rsp_valid, rsp_err, mem_req, mem_we, mem_be});
        end
        vectors++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h want 0",
                     mem_addr, mem_wdata, rsp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lbu;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL lbu_ready: got %b want 1", req_ready);
        end
        issue(1'b0, 3'b100, 32'h0000_1003, 32'h0);
        vectors++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_1000}) begin
            miscompares++;
            $display("FAIL lbu_mem: req %b we %b addr %h want 1 0 00001000",
                     mem_req, mem_we, mem_addr);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF_0000;
        vectors++;
        if ({mem_req, rsp_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL lbu_wait: req %b rsp_valid %b want 0 0", mem_req, rsp_valid);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0000_0080}) begin
            miscompares++;
            $display("FAIL lbu_rsp: valid %b err %b rdata %h want 1 0 00000080",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL lbu_done: valid %b ready %b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_lh;
        issue(1'b0, 3'b001, 32'h0000_2002, 32'h0);
        vectors++;
        if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h0000_2000, 4'b1100}) begin
            miscompares++;
            $display("FAIL lh_mem: req %b addr %h be %b want 1 00002000 1100",
                     mem_req, mem_addr, mem_be);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_1234;
        @(negedge clk);
        mem_rvalid = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hFFFF_8001}) begin
            miscompares++;
            $display("FAIL lh_rsp: valid %b err %b rdata %h want 1 0 ffff8001",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_load_extend;
        logic [2:0]  f3s [4];
        logic [31:0] adr [4];
        logic [31:0] wrd [4];
        logic [31:0] exp [4];
        f3s = '{3'b000, 3'b101, 3'b010, 3'b000};
        adr = '{32'h5001, 32'h5002, 32'h5004, 32'h5000};
        wrd = '{32'h1234_80FF, 32'h9ABC_0000, 32'hDEAD_BEEF, 32'h0000_007F};
        exp = '{32'hFFFF_FF80, 32'h0000_9ABC, 32'hDEAD_BEEF, 32'h0000_007F};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3s[i], adr[i], 32'h0);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = wrd[i];
            @(negedge clk);
            mem_rvalid = 1'b0;
            vectors++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp[i]}) begin
                miscompares++;
                $display("FAIL ext_%0d: valid %b err %b rdata %h want 1 0 %h",
                         i, rsp_valid, rsp_err, rsp_rdata, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sb_stall;
        int req_cycles;
        issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB);
        req_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            if (mem_req === 1'b1) req_cycles++;
            if (c == 4) mem_gnt = 1'b1;
            if (c < 4) @(negedge clk);
        end
        vectors++;
        if ({mem_we, mem_be, mem_wdata} !== {1'b1, 4'b0010, 32'h0000_AB00}) begin
            miscompares++;
            $display("FAIL sb_mem: we %b be %b wdata %h want 1 0010 0000ab00",
                     mem_we, mem_be, mem_wdata);
        end
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_early: rsp_valid %b want 0", rsp_valid);
        end
        @(negedge clk);
        mem_gnt = 1'b0;
        vectors++;
        if (req_cycles != 5) begin
            miscompares++;
            $display("FAIL sb_req_len: got %0d cycles want 5", req_cycles);
        end
        vectors++;
        if ({rsp_valid, rsp_err, mem_req, rsp_rdata} !== {3'b100, 32'h0}) begin
            miscompares++;
            $display("FAIL sb_rsp: valid %b err %b req %b rdata %h want 1 0 0 0",
                     rsp_valid, rsp_err, mem_req, rsp_rdata);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL sb_done: valid %b ready %b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_errors;
        logic        wes [6];
        logic [2:0]  f3s [6];
        logic [31:0] adr [6];
        wes = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        f3s = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b111, 3'b001};
        adr = '{32'h4002, 32'h4001, 32'h4000, 32'h4000, 32'h4000, 32'h4003};
        for (int i = 0; i < 6; i++) begin
            issue(wes[i], f3s[i], adr[i], 32'hFFFF_FFFF);
            vectors++;
            if ({rsp_valid, rsp_err, mem_req, rsp_rdata} !== {3'b110, 32'h0}) begin
                miscompares++;
                $display("FAIL err_%0d: valid %b err %b req %b rdata %h want 1 1 0 0",
                         i, rsp_valid, rsp_err, mem_req, rsp_rdata);
            end
            @(negedge clk);
            vectors++;
            if ({rsp_valid, req_ready, mem_req} !== 3'b010) begin
                miscompares++;
                $display("FAIL err_%0d_done: valid %b ready %b req %b want 0 1 0",
                         i, rsp_valid, req_ready, mem_req);
            end
        end
    endtask

    task automatic test_timeout;
        int early;
        int late;
        issue(1'b0, 3'b010, 32'h0000_6000, 32'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        early = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid === 1'b1) early++;
            @(negedge clk);
        end
        vectors++;
        if (early != 0) begin
            miscompares++;
            $display("FAIL to_early: rsp_valid seen %0d times want 0", early);
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
            miscompares++;
            $display("FAIL to_rsp: valid %b err %b rdata %h want 1 1 0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        late = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rsp_valid === 1'b1) late++;
        end
        vectors++;
        if (late != 0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL to_late: rsp_valid seen %0d ready %b want 0 1", late, req_ready);
        end
    endtask

    task automatic test_reset_wait;
        int spur;
        issue(1'b0, 3'b010, 32'h0000_7000, 32'hCAFE_F00D);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we, mem_be} !== 9'b1_0000_0000
            || {mem_addr, mem_wdata, rsp_rdata} !== 96'h0) begin
            miscompares++;
            $display("FAIL rst_async: ctl %b addr %h want 100000000 0",
                     {req_ready, rsp_valid, rsp_err, mem_req, mem_we, mem_be}, mem_addr);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        spur = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            if (rsp_valid === 1'b1) spur++;
        end
        mem_rvalid = 1'b0;
        vectors++;
        if (spur != 0) begin
            miscompares++;
            $display("FAIL rst_spur: rsp_valid seen %0d times want 0", spur);
        end
        issue(1'b0, 3'b010, 32'h0000_7004, 32'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h1111_2222}) begin
            miscompares++;
            $display("FAIL rst_next: valid %b err %b rdata %h want 1 0 11112222",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        test_reset();
        test_lbu();
        test_lh();
        test_load_extend();
        test_sb_stall();
        test_errors();
        test_timeout();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
